mips_regfile_mp: RTL

Parametrised multi-port register file for the OpenMIPS pipeline, serving the decode stage (N read ports) and the write-back stage (two write ports). It adds write-to-read forwarding on both write ports, a post-reset hardware clear sequencer and a per-register busy scoreboard for pending writes. The decode stage uses the scoreboard to detect hazards.

---
 rtl/mips_rf_pkg.sv | 16 +
 rtl/mips_regfile_mp_if.sv | 34 +++
 rtl/mips_rf_read_port.sv | 44 ++++
 rtl/mips_regfile_mp.sv | 94 +++++++++
 4 files changed

// File: rtl/mips_rf_pkg.sv
// Shared types and defaults for the OpenMIPS multi-port register file.
package mips_rf_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_RD_DEF   = 3;
  localparam int ZERO_REG_DEF = 1;

  localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/mips_regfile_mp_if.sv
// Decode/write-back side bus of the register file: two write ports, reserve, N read ports.
interface mips_regfile_mp_if
  import mips_rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
);

  logic                       ready;
  logic                       we0;
  logic [ADDR_W-1:0]          waddr0;
  logic [DATA_W-1:0]          wdata0;
  logic                       we1;
  logic [ADDR_W-1:0]          waddr1;
  logic [DATA_W-1:0]          wdata1;
  logic                       rsv_en;
  logic [ADDR_W-1:0]          rsv_addr;
  logic [NUM_RD-1:0]          re;
  logic [NUM_RD*ADDR_W-1:0]   raddr;
  logic [NUM_RD*DATA_W-1:0]   rdata;
  logic [NUM_RD-1:0]          rbusy;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, rsv_en, rsv_addr, re, raddr,
    input  ready, rdata, rbusy
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, rsv_en, rsv_addr, re, raddr,
    output ready, rdata, rbusy
  );

endinterface

// File: rtl/mips_rf_read_port.sv
// One read port: zero/enable gating, write-to-read forwarding and hazard (busy) flag.
module mips_rf_read_port
  import mips_rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic              rst,
  input  rf_state_e         state,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] word,
  input  logic              busy_bit,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata,
  output logic              rbusy
);

  logic hit0, hit1, is_zero;

  assign hit0    = we0 && (waddr0 == addr);
  assign hit1    = we1 && (waddr1 == addr);
  assign is_zero = (ZERO_REG != 0) && (addr == '0);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    rdata = DATA_W'(ZERO_WORD);
    rbusy = 1'b0;
    if (!rst && state == READY && re && !is_zero) begin
      if (hit1)      rdata = wdata1;
      else if (hit0) rdata = wdata0;
      else           rdata = word;
      // A write landing this cycle is forwarded, so it is no longer a hazard.
      rbusy = busy_bit && !(hit0 || hit1);
    end
  end

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-port register file: storage, busy scoreboard, post-reset clear sequencer, read ports.
module mips_regfile_mp
  import mips_rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input logic              clk,
  input logic              rst,
  mips_regfile_mp_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  rf_state_e         state;
  logic [ADDR_W-1:0] clr_idx;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              active, wr0, wr1, rsv;

  assign active = (state == READY) && !rst;
  assign wr0    = active && bus.we0 && !((ZERO_REG != 0) && (bus.waddr0 == '0));
  assign wr1    = active && bus.we1 && !((ZERO_REG != 0) && (bus.waddr1 == '0));
  assign rsv    = bus.rsv_en && !((ZERO_REG != 0) && (bus.rsv_addr == '0));

  assign bus.ready = (state == READY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == ADDR_W'(DEPTH - 1)) state <= READY;
    end
  end

  // NOTE: storage carries no reset; the clear sequencer zeroes one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (!rst && state == CLEAR) begin
      regs[clr_idx] <= DATA_W'(ZERO_WORD);
    end else begin
      // NOTE: non-blocking, so the later port-1 assignment wins on an address collision.
      if (wr0) regs[bus.waddr0] <= bus.wdata0;
      if (wr1) regs[bus.waddr1] <= bus.wdata1;
    end
  end

  // Reserve is applied after the write clears so a same-cycle reserve leaves the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (state == READY) begin
      if (bus.we0) busy[bus.waddr0]   <= 1'b0;
      if (bus.we1) busy[bus.waddr1]   <= 1'b0;
      if (rsv)     busy[bus.rsv_addr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] port_data;
    logic              port_busy;

    assign addr = bus.raddr[i*ADDR_W +: ADDR_W];

    mips_rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_port (
      .rst     (rst),
      .state   (state),
      .re      (bus.re[i]),
      .addr    (addr),
      .word    (regs[addr]),
      .busy_bit(busy[addr]),
      .we0     (bus.we0),
      .waddr0  (bus.waddr0),
      .wdata0  (bus.wdata0),
      .we1     (bus.we1),
      .waddr1  (bus.waddr1),
      .wdata1  (bus.wdata1),
      .rdata   (port_data),
      .rbusy   (port_busy)
    );

    assign bus.rdata[i*DATA_W +: DATA_W] = port_data;
    assign bus.rbusy[i]                  = port_busy;
  end

endmodule
